// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the MIPS instruction fetch front end: FSM encodings,
// the reset fetch address and the instruction width.
package mips_fetch_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] RESET_PC_DEFAULT = 32'h0040_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    FULL = 2'd2
  } fetch_state_e;

  function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
    return {addr[INSTR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: program memory port, redirect/stall control from the pipeline
// and the head-of-queue presentation to IF/ID.
interface instruction_fetch_unit_if #(
  parameter int DEPTH = 4
);
  import mips_fetch_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               imem_req;
  logic [INSTR_W-1:0] imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [INSTR_W-1:0] redirect_pc;
  logic               stall;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [INSTR_W-1:0] if_pc;
  logic [INSTR_W-1:0] if_pc4;
  logic [CNT_W-1:0]   queue_count;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4, queue_count,
    input  imem_rdata, redirect_valid, redirect_pc, stall
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4, queue_count,
    output imem_rdata, redirect_valid, redirect_pc, stall
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue: power-of-two circular buffer with wrap-around pointers,
// an occupancy count, synchronous flush and a combinational head output.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt;

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      cnt <= cnt + (PTR_W+1)'(1);
      else if (pop && !push) cnt <= cnt - (PTR_W+1)'(1);
    end
  end

  // Storage carries no reset; entries are only observable once counted.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues one-cycle-latency program memory reads into a
// prefetch queue, presents the head to IF/ID, and flushes on redirect.
module instruction_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  instruction_fetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [INSTR_W-1:0] req_addr_q;
  logic               inflight_q;
  logic               kill_q;

  logic               req;
  logic               push;
  logic               pop;
  logic               flush;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic [OCC_W-1:0]   occ_next;
  logic [63:0]        head;
  logic               head_valid;
  logic [INSTR_W-1:0] head_pc;

  // RUN already implies queue_count + inflight < DEPTH, so the state alone gates requests.
  assign req   = reset && (state_q == RUN);
  assign flush = bus.redirect_valid;
  assign push  = inflight_q && !kill_q && !bus.redirect_valid;
  assign pop   = head_valid && !bus.stall && !bus.redirect_valid;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_next = count;
    if (push && !pop)      count_next = count + CNT_W'(1);
    else if (pop && !push) count_next = count - CNT_W'(1);
    if (flush)             count_next = '0;
    occ_next = {1'b0, count_next} + OCC_W'(req);

    case (state_q)
      BOOT:      state_d = RUN;
      RUN, FULL: state_d = (occ_next >= DEPTH_OCC) ? FULL : RUN;
      default:   state_d = BOOT;
    endcase

    if (bus.redirect_valid) begin
      state_d    = RUN;
      fetch_pc_d = word_align(bus.redirect_pc);
    end else if (req) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= req;
      kill_q     <= bus.redirect_valid && req;
    end
  end

  // Request stage -> response stage: remember the address of the outstanding read.
  always_ff @(posedge clk) begin
    if (req) req_addr_q <= fetch_pc_q;
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({bus.imem_rdata, req_addr_q}),
    .head  (head),
    .count (count)
  );

  // Head presentation: zeroed while empty so reset and flush show a clean IF/ID view.
  assign head_valid      = (count != '0);
  assign head_pc         = head_valid ? head[31:0] : '0;
  assign bus.if_valid    = head_valid;
  assign bus.if_instr    = head_valid ? head[63:32] : '0;
  assign bus.if_pc       = head_pc;
  assign bus.if_pc4      = head_pc + 32'd4;
  assign bus.imem_req    = req;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.queue_count = count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a one-cycle-latency ROM model
// whose word at address A is (A - 0x0040_0000) >> 2.
module tb_instruction_fetch_unit;
  import mips_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam int          DEPTH  = 4;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  instruction_fetch_unit_if #(.DEPTH(DEPTH)) bus ();

  instruction_fetch_unit #(
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rom(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - RST_PC;
    return off >> 2;
  endfunction

  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= rom(bus.imem_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    check("no_overflow", {31'b0, bus.queue_count <= 3'(DEPTH)}, 32'd1);
    check("valid_vs_count", {31'b0, bus.if_valid}, {31'b0, bus.queue_count != 3'd0});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset              = 1'b0;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_rdata     = '0;
    repeat (3) tick();

    check("rst_req",    {31'b0, bus.imem_req}, 32'd0);
    check("rst_valid",  {31'b0, bus.if_valid}, 32'd0);
    check("rst_instr",  bus.if_instr, 32'd0);
    check("rst_pc",     bus.if_pc, 32'd0);
    check("rst_pc4",    bus.if_pc4, 32'd4);
    check("rst_addr",   bus.imem_addr, RST_PC);
    check("rst_count",  32'(bus.queue_count), 32'd0);
    check("rst_state",  32'(dut.state_q), 32'(BOOT));

    // Reset release: one BOOT cycle without a request, then fetch from RESET_PC.
    reset = 1'b1;
    check("boot_no_req", {31'b0, bus.imem_req}, 32'd0);
    tick();
    check("first_req",   {31'b0, bus.imem_req}, 32'd1);
    check("first_addr",  bus.imem_addr, RST_PC);
    check("first_valid", {31'b0, bus.if_valid}, 32'd0);
    tick();
    check("second_addr",  bus.imem_addr, 32'h0040_0004);
    check("second_valid", {31'b0, bus.if_valid}, 32'd0);
    tick();
    check("lat_valid", {31'b0, bus.if_valid}, 32'd1);
    check("lat_instr", bus.if_instr, 32'd0);
    check("lat_pc",    bus.if_pc, 32'h0040_0000);
    check("lat_pc4",   bus.if_pc4, 32'h0040_0004);
    tick();
    check("steady_pc",    bus.if_pc, 32'h0040_0004);
    check("steady_instr", bus.if_instr, 32'd1);
    check("steady_count", 32'(bus.queue_count), 32'd1);

    // Stall for 10 cycles: head held, queue fills and fetching stops in FULL.
    bus.stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_pc",    bus.if_pc, 32'h0040_0004);
      check("stall_instr", bus.if_instr, 32'd1);
    end
    check("stall_count", 32'(bus.queue_count), 32'd4);
    check("stall_state", 32'(dut.state_q), 32'(FULL));
    check("stall_req",   {31'b0, bus.imem_req}, 32'd0);

    bus.stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("drain_pc",    bus.if_pc, 32'h0040_0008 + 32'(4 * k));
      check("drain_instr", bus.if_instr, 32'(2 + k));
    end

    // Redirect with a request in flight: its response must be discarded.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0040_0103;
    tick();
    check("redir_req",   {31'b0, bus.imem_req}, 32'd1);
    check("redir_addr",  bus.imem_addr, 32'h0040_0100);
    check("redir_valid", {31'b0, bus.if_valid}, 32'd0);
    check("redir_count", 32'(bus.queue_count), 32'd0);
    bus.redirect_valid = 1'b0;
    tick();
    check("redir_push_cycle", {31'b0, bus.if_valid}, 32'd0);
    tick();
    check("redir_head_pc",    bus.if_pc, 32'h0040_0100);
    check("redir_head_instr", bus.if_instr, 32'h0000_0040);
    check("redir_head_pc4",   bus.if_pc4, 32'h0040_0104);
    tick();
    check("redir_next_pc",    bus.if_pc, 32'h0040_0104);

    // Fill the queue under stall, then redirect+stall together to the top of memory.
    bus.stall = 1'b1;
    n = 0;
    while (bus.queue_count != 3'd4 && n < 20) begin
      tick();
      n++;
    end
    check("fill_count", 32'(bus.queue_count), 32'd4);
    check("fill_state", 32'(dut.state_q), 32'(FULL));
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick();
    check("flush_count", 32'(bus.queue_count), 32'd0);
    check("flush_valid", {31'b0, bus.if_valid}, 32'd0);
    check("flush_req",   {31'b0, bus.imem_req}, 32'd1);
    check("flush_addr",  bus.imem_addr, 32'hFFFF_FFFC);
    bus.redirect_valid = 1'b0;
    bus.stall          = 1'b0;
    tick();
    check("wrap_addr",  bus.imem_addr, 32'h0000_0000);
    tick();
    check("wrap_pc0",    bus.if_pc, 32'hFFFF_FFFC);
    check("wrap_pc4_0",  bus.if_pc4, 32'h0000_0000);
    check("wrap_instr0", bus.if_instr, rom(32'hFFFF_FFFC));
    tick();
    check("wrap_pc1",    bus.if_pc, 32'h0000_0000);
    check("wrap_pc4_1",  bus.if_pc4, 32'h0000_0004);
    check("wrap_instr1", bus.if_instr, rom(32'h0000_0000));

    // Mid-operation reset with three entries queued.
    bus.stall = 1'b1;
    n = 0;
    while (bus.queue_count != 3'd3 && n < 20) begin
      tick();
      n++;
    end
    check("pre_rst_count", 32'(bus.queue_count), 32'd3);
    reset = 1'b0;
    tick();
    check("mid_rst_count", 32'(bus.queue_count), 32'd0);
    check("mid_rst_valid", {31'b0, bus.if_valid}, 32'd0);
    check("mid_rst_req",   {31'b0, bus.imem_req}, 32'd0);
    check("mid_rst_addr",  bus.imem_addr, RST_PC);
    reset     = 1'b1;
    bus.stall = 1'b0;
    check("mid_boot_req", {31'b0, bus.imem_req}, 32'd0);
    tick();
    check("post_rst_count", 32'(bus.queue_count), 32'd0);
    check("post_rst_req",   {31'b0, bus.imem_req}, 32'd1);
    check("post_rst_addr",  bus.imem_addr, RST_PC);
    tick();
    check("post_rst_valid", {31'b0, bus.if_valid}, 32'd0);
    tick();
    check("post_rst_pc",    bus.if_pc, RST_PC);
    check("post_rst_instr", bus.if_instr, 32'd0);

    // Redirect during BOOT, then back-to-back redirects where the last wins.
    reset = 1'b0;
    tick();
    reset              = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0040_0200;
    tick();
    check("bootredir_state", 32'(dut.state_q), 32'(RUN));
    check("bootredir_addr",  bus.imem_addr, 32'h0040_0200);
    check("bootredir_req",   {31'b0, bus.imem_req}, 32'd1);
    bus.redirect_pc = 32'h0040_0300;
    tick();
    check("b2b_addr1",  bus.imem_addr, 32'h0040_0300);
    check("b2b_valid1", {31'b0, bus.if_valid}, 32'd0);
    bus.redirect_pc = 32'h0040_0402;
    tick();
    check("b2b_addr2",  bus.imem_addr, 32'h0040_0400);
    bus.redirect_valid = 1'b0;
    tick();
    check("b2b_push_cycle", {31'b0, bus.if_valid}, 32'd0);
    tick();
    check("b2b_pc",    bus.if_pc, 32'h0040_0400);
    check("b2b_instr", bus.if_instr, 32'h0000_0100);
    tick();
    check("b2b_next_pc", bus.if_pc, 32'h0040_0404);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
